// File: rtl/mmss_countdown.sv
// MM:SS BCD countdown timer: preset load, per-tick decrement with seconds->minutes borrow,
// and a timed alarm at 00:00 that returns to idle on its own or when acknowledged by stop.
module mmss_countdown #(
  parameter int MAX_MIN     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick,
  input  logic       ld,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       borrow,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] ALARM_INIT  = 8'(ALARM_TICKS);

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] cnt_q, cnt_d;
  logic       borrow_q, borrow_d;
  logic       alarm_q, alarm_d;
  logic       running_q, running_d;
  logic       done_q, done_d;

  function automatic logic [7:0] sanitize_sec(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h59;
    return v;
  endfunction

  function automatic logic [7:0] sanitize_min(input logic [7:0] v);
    logic [6:0] dec;
    dec = 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || dec > 7'(MAX_MIN)) return MAX_MIN_BCD;
    return v;
  endfunction

  // Two-digit BCD minus one; caller guarantees a non-zero operand.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    return {v[7:4] - 4'd1, 4'd9};
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      cnt_q     <= 8'd0;
      borrow_q  <= 1'b0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    cnt_d    = cnt_q;
    borrow_d = 1'b0;
    alarm_d  = alarm_q;
    if (ld) begin
      state_d = S_IDLE;
      min_d   = sanitize_min(ld_min);
      sec_d   = sanitize_sec(ld_sec);
      alarm_d = 1'b0;
      cnt_d   = 8'd0;
    end else if (stop && state_q != S_IDLE) begin
      // A stop that changes state consumes the cycle, so a coincident tick is dropped.
      case (state_q)
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          alarm_d = 1'b0;
          cnt_d   = 8'd0;
        end
      endcase
    end else if (start && (state_q == S_PAUSE ||
                           (state_q == S_IDLE && (min_q != 8'h00 || sec_q != 8'h00)))) begin
      state_d = S_RUN;
    end else if (tick) begin
      if (state_q == S_RUN) begin
        if (sec_q != 8'h00) begin
          sec_d = bcd_dec(sec_q);
          if (min_q == 8'h00 && sec_q == 8'h01) begin
            state_d = S_DONE;
            alarm_d = 1'b1;
            cnt_d   = ALARM_INIT;
          end
        end else if (min_q != 8'h00) begin
          sec_d    = 8'h59;
          min_d    = bcd_dec(min_q);
          borrow_d = 1'b1;
        end else begin
          state_d = S_DONE;
          alarm_d = 1'b1;
          cnt_d   = ALARM_INIT;
        end
      end else if (state_q == S_DONE) begin
        if (cnt_q <= 8'd1) begin
          state_d = S_IDLE;
          alarm_d = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    end
  end

  always_comb begin
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    min_bcd   = min_q;
    sec_bcd   = sec_q;
    borrow    = borrow_q;
    running   = running_q;
    done      = done_q;
    alarm     = alarm_q;
  end

endmodule

// File: tb/tb_mmss_countdown.sv
// Bench for mmss_countdown: vector table plus hand sequences for alarm timeout and async reset.
module tb_mmss_countdown;

  logic       clk = 1'b0;
  logic       clrn, tick, ld, start, stop;
  logic [7:0] ld_min, ld_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       borrow, running, done, alarm;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       ld;
    logic [7:0] ld_min;
    logic [7:0] ld_sec;
    logic       start;
    logic       stop;
    logic       tick;
    logic [7:0] e_min;
    logic [7:0] e_sec;
    logic       e_bor;
    logic       e_run;
    logic       e_done;
    logic       e_alarm;
  } vec_t;

  typedef struct {
    string      name;
    logic [19:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  mmss_countdown #(.MAX_MIN(59), .ALARM_TICKS(10)) dut (
    .clk(clk), .clrn(clrn), .tick(tick), .ld(ld), .ld_min(ld_min), .ld_sec(ld_sec),
    .start(start), .stop(stop), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .borrow(borrow),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic l, input logic [7:0] lm, input logic [7:0] ls,
                              input logic sa, input logic so, input logic tk,
                              input logic [7:0] em, input logic [7:0] es, input logic eb,
                              input logic er, input logic ed, input logic ea);
    vec_t v;
    v.ld = l; v.ld_min = lm; v.ld_sec = ls; v.start = sa; v.stop = so; v.tick = tk;
    v.e_min = em; v.e_sec = es; v.e_bor = eb; v.e_run = er; v.e_done = ed; v.e_alarm = ea;
    return v;
  endfunction

  function automatic logic [19:0] outs();
    return {min_bcd, sec_bcd, borrow, running, done, alarm};
  endfunction

  task automatic compare(input string name, input logic [19:0] got, input logic [19:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got min=%h sec=%h bor/run/done/alm=%b, expected min=%h sec=%h bor/run/done/alm=%b",
               name, got[19:12], got[11:4], got[3:0], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, and check after the edge.
  task automatic cyc(input vec_t v, input string name);
    exp_t e;
    ld = v.ld; ld_min = v.ld_min; ld_sec = v.ld_sec;
    start = v.start; stop = v.stop; tick = v.tick;
    sb.push_back('{name, {v.e_min, v.e_sec, v.e_bor, v.e_run, v.e_done, v.e_alarm}});
    @(posedge clk);
    #1;
    ld = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    e = sb.pop_front();
    compare(e.name, outs(), e.val);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    clrn = 1'b0; tick = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0;
    ld_min = 8'h00; ld_sec = 8'h00;

    //            ld lmin   lsec   sa so tk  emin   esec   b  r  d  a
    // countdown within seconds: units wrap and tens borrow
    vecs.push_back(mk(1, 8'h00, 8'h12, 0, 0, 0, 8'h00, 8'h12, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h12, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h11, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h10, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h09, 0, 1, 0, 0));
    // minutes borrow pulse lasts one clk
    vecs.push_back(mk(1, 8'h02, 8'h00, 0, 0, 0, 8'h02, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 8'h59, 1, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h59, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 8'h58, 0, 1, 0, 0));
    // reach 00:00, start ignored in DONE, stop acknowledges early
    vecs.push_back(mk(1, 8'h00, 8'h02, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h02, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h01, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    // pause/resume: stop beats a coincident tick, paused ticks ignored
    vecs.push_back(mk(1, 8'h00, 8'h45, 0, 0, 0, 8'h00, 8'h45, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h45, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h45, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h45, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h45, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h44, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h44, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h44, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h44, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h44, 0, 0, 0, 0));
    // load sanitising, start at 00:00 ignored, load during RUN wins over tick
    vecs.push_back(mk(1, 8'h75, 8'h6A, 0, 0, 0, 8'h59, 8'h59, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h9A, 8'h5F, 0, 0, 0, 8'h59, 8'h59, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h60, 8'h00, 0, 0, 0, 8'h59, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h03, 8'h20, 0, 0, 0, 8'h03, 8'h20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h03, 8'h20, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h03, 8'h19, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h00, 8'h30, 0, 0, 1, 8'h00, 8'h30, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h30, 0, 0, 0, 0));
    // minutes tens borrow 10:00 -> 09:59
    vecs.push_back(mk(1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h09, 8'h59, 1, 1, 0, 0));

    #12;
    compare("reset_state", outs(), 20'h0);
    release_reset();
    cyc(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "idle_after_reset");

    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i], $sformatf("vec%0d", i));

    // Alarm times out after ALARM_TICKS ticks in DONE.
    cyc(mk(1, 8'h00, 8'h01, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0), "alarm_ld");
    cyc(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h01, 0, 1, 0, 0), "alarm_start");
    cyc(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1), "alarm_done");
    for (int i = 1; i <= 10; i++)
      cyc(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, i < 10, i < 10),
          $sformatf("alarm_tick%0d", i));
    cyc(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0), "alarm_idle_start");

    // Asynchronous reset mid-RUN at 01:30 clears outputs without a clock edge.
    cyc(mk(1, 8'h01, 8'h30, 0, 0, 0, 8'h01, 8'h30, 0, 0, 0, 0), "rst_run_ld");
    cyc(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h30, 0, 1, 0, 0), "rst_run_start");
    #2;
    clrn = 1'b0;
    #1;
    compare("rst_async_run", outs(), 20'h0);
    release_reset();
    cyc(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "rst_run_after");

    // Asynchronous reset while DONE with alarm high.
    cyc(mk(1, 8'h00, 8'h01, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0), "rst_done_ld");
    cyc(mk(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h01, 0, 1, 0, 0), "rst_done_start");
    cyc(mk(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 1), "rst_done_enter");
    #2;
    clrn = 1'b0;
    #1;
    compare("rst_async_done", outs(), 20'h0);
    release_reset();
    cyc(mk(0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0), "rst_done_after");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
